l1_lc_arbiter: RTL and testbench
================================

Name: l1_lc_arbiter

Overview:
- Shares the single lower-cache (LC) request/response channel between the L1 data cache (D port) and the L1 instruction cache (I port).
- Round-robin arbitration, one registered request stage toward the LC, and an in-order owner FIFO that routes LC read responses back to the originating L1.
- Sits between both L1s and the LC.

Parameters:
- PADDR_BITS, 22, physical line-address width.
- LINE_BITS, 512, cache line width (B=64 bytes).
- MAX_OUTSTANDING, 4, owner-FIFO depth, i.e. the maximum number of LC reads in flight. Power of two, at least 2.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- d_valid_in  input  1  D request valid
- d_ready_out  output  1  D request accepted this cycle
- d_addr_in  input  PADDR_BITS  D request address
- d_value_in  input  LINE_BITS  D writeback data
- d_we_in  input  1  D request is a writeback
- i_valid_in  input  1  I request valid; reads only
- i_ready_out  output  1  I request accepted this cycle
- i_addr_in  input  PADDR_BITS  I request address
- d_rsp_valid_out  output  1  response valid to D
- d_rsp_ready_in  input  1  D ready for response
- i_rsp_valid_out  output  1  response valid to I
- i_rsp_ready_in  input  1  I ready for response
- rsp_addr_out  output  PADDR_BITS  response address, shared by D and I
- rsp_value_out  output  LINE_BITS  response line, shared by D and I
- lc_valid_out  output  1  request valid to LC
- lc_ready_in  input  1  LC accepts request
- lc_addr_out  output  PADDR_BITS  request address to LC
- lc_value_out  output  LINE_BITS  writeback data to LC
- lc_we_out  output  1  request is a write
- lc_valid_in  input  1  LC response valid
- lc_ready_out  output  1  arbiter accepts LC response
- lc_addr_in  input  PADDR_BITS  LC response address
- lc_value_in  input  LINE_BITS  LC response data
- outstanding_out  output  $clog2(MAX_OUTSTANDING)+1  reads in flight
- unexpected_rsp_out  output  1  one-cycle pulse: LC response arrived with the FIFO empty

Behaviour:
- Reset (async, rst_in=1):
  - FSM to IDLE; holding register invalid; owner FIFO emptied; last_grant=I (D wins the first tie).
  - All outputs 0, except lc_ready_out=1 (FIFO empty).
- FSM states: IDLE, SEND.
- IDLE:
  - Eligible requester: valid_in=1, and if a read, FIFO not full.
  - Both eligible: grant the one opposite last_grant. One eligible: grant it.
  - Winner's ready_out=1 combinationally that cycle (handshake). Address, data and we latch into the holding register; last_grant updates.
  - A read pushes the owner ID into the FIFO on acceptance. A write pushes nothing; writes get no LC response.
  - Go to SEND. I requests always carry lc_we_out=0.
- SEND:
  - lc_valid_out=1, driven from the holding register; held stable until lc_ready_in=1.
  - On that handshake, return to IDLE next cycle. Throughput is at most one request per 2 cycles.
  - No ready_out is asserted in SEND.
- Full FIFO: reads are not eligible (ready_out=0); writes remain eligible. A pop in the same cycle does not free a slot for that cycle's accept.
- Response path (combinational):
  - FIFO head=D: d_rsp_valid_out=lc_valid_in; lc_ready_out=d_rsp_ready_in. Same for I.
  - rsp_addr_out/rsp_value_out = lc_addr_in/lc_value_in.
  - Pop on lc_valid_in && lc_ready_out.
  - FIFO empty: lc_ready_out=1, both rsp_valid=0; a response with lc_valid_in=1 is dropped and unexpected_rsp_out pulses for 1 cycle.
- Simultaneous push (IDLE accept) and pop: both occur; outstanding_out is unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING; a count register distinguishes full from empty. outstanding_out equals the count.
- Requesters must hold valid and payload until ready. Dropping valid before ready is legal; no grant occurs.
- Reset mid-SEND: request discarded, lc_valid_out drops immediately (async).
- Responses from the LC return in request order; no address matching is performed.

Test Plan:
- D read 0x02000 alone:
  - d_ready_out same cycle; next cycle lc_valid_out=1, lc_addr_out=0x02000, lc_we_out=0; outstanding_out=1.
  - LC returns 512'hDEADBEEF: d_rsp_valid_out=1 with that value, i_rsp_valid_out=0; outstanding_out back to 0.
- D and I both valid every cycle (D 0x04040, I 0x01000) from reset:
  - LC order D, I, D, I (alternating grants).
  - Responses 0xA, 0xB, in order: 0xA to D, 0xB to I.
- D writeback (d_we_in=1, 0x05000, data 0x55AA):
  - lc_we_out=1 with that value; outstanding_out stays 0.
  - A following I read still routes the next response to I.
- Four reads accepted with lc_valid_in=0: outstanding_out=4.
  - A fifth D read sees d_ready_out=0 for as long as the FIFO stays full.
  - A D write is still accepted.
  - After one response pops, the fifth read is accepted on a later IDLE cycle.
- Backpressure:
  - lc_ready_in=0 for 5 cycles: lc_addr_out and lc_value_out stable, no new ready_out.
  - i_rsp_ready_in=0 with head=I: lc_ready_out=0 until it rises.
- Error and reset cases:
  - lc_valid_in=1 with the FIFO empty: unexpected_rsp_out pulses 1 cycle, lc_ready_out=1.
  - rst_in asserted mid-SEND: lc_valid_out=0 immediately, outstanding_out=0.

Source files
------------

// File: rtl/l1_lc_arbiter.sv
// Shares one lower-cache request/response channel between the L1 D and I caches.
// Round-robin grant, one registered request stage, in-order owner FIFO for read responses.
`timescale 1ns/1ps
module l1_lc_arbiter #(
  parameter int PADDR_BITS      = 22,
  parameter int LINE_BITS       = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 d_valid_in,
  output logic                                 d_ready_out,
  input  logic [PADDR_BITS-1:0]                d_addr_in,
  input  logic [LINE_BITS-1:0]                 d_value_in,
  input  logic                                 d_we_in,
  input  logic                                 i_valid_in,
  output logic                                 i_ready_out,
  input  logic [PADDR_BITS-1:0]                i_addr_in,
  output logic                                 d_rsp_valid_out,
  input  logic                                 d_rsp_ready_in,
  output logic                                 i_rsp_valid_out,
  input  logic                                 i_rsp_ready_in,
  output logic [PADDR_BITS-1:0]                rsp_addr_out,
  output logic [LINE_BITS-1:0]                 rsp_value_out,
  output logic                                 lc_valid_out,
  input  logic                                 lc_ready_in,
  output logic [PADDR_BITS-1:0]                lc_addr_out,
  output logic [LINE_BITS-1:0]                 lc_value_out,
  output logic                                 lc_we_out,
  input  logic                                 lc_valid_in,
  output logic                                 lc_ready_out,
  input  logic [PADDR_BITS-1:0]                lc_addr_in,
  input  logic [LINE_BITS-1:0]                 lc_value_in,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_out,
  output logic                                 unexpected_rsp_out
);

  localparam int PTR_BITS = $clog2(MAX_OUTSTANDING);
  localparam int CNT_BITS = PTR_BITS + 1;

  typedef enum logic {IDLE, SEND} state_t;
  typedef enum logic {OWNER_D, OWNER_I} owner_t;

  state_t                state, state_next;
  owner_t                last_grant;
  logic [PADDR_BITS-1:0] hold_addr;
  logic [LINE_BITS-1:0]  hold_value;
  logic                  hold_we;

  owner_t                owner_mem [MAX_OUTSTANDING];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]   count;

  logic fifo_full, fifo_empty;
  logic d_elig, i_elig;
  logic grant_d, grant_i;
  logic push, pop;
  owner_t head;

  // Eligibility uses the registered count, so a same-cycle pop never frees a slot early.
  assign fifo_full  = (count == CNT_BITS'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign d_elig     = d_valid_in && (d_we_in || !fifo_full);
  assign i_elig     = i_valid_in && !fifo_full;
  assign head       = owner_mem[rd_ptr];

  // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state)
      IDLE: begin
        if (d_elig && (!i_elig || last_grant == OWNER_I)) grant_d = 1'b1;
        else if (i_elig)                                  grant_i = 1'b1;
        if (grant_d || grant_i) state_next = SEND;
      end
      SEND: if (lc_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign d_ready_out  = grant_d;
  assign i_ready_out  = grant_i;
  assign push         = (grant_d && !d_we_in) || grant_i;
  assign lc_valid_out = (state == SEND);
  assign lc_addr_out  = hold_addr;
  assign lc_value_out = hold_value;
  assign lc_we_out    = hold_we;

  always_comb begin
    d_rsp_valid_out    = 1'b0;
    i_rsp_valid_out    = 1'b0;
    lc_ready_out       = 1'b1;
    unexpected_rsp_out = 1'b0;
    if (fifo_empty) begin
      unexpected_rsp_out = lc_valid_in;
    end else if (head == OWNER_D) begin
      d_rsp_valid_out = lc_valid_in;
      lc_ready_out    = d_rsp_ready_in;
    end else begin
      i_rsp_valid_out = lc_valid_in;
      lc_ready_out    = i_rsp_ready_in;
    end
  end

  assign pop             = lc_valid_in && lc_ready_out && !fifo_empty;
  assign rsp_addr_out    = lc_addr_in;
  assign rsp_value_out   = lc_value_in;
  assign outstanding_out = count;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      last_grant <= OWNER_I;
      hold_addr  <= '0;
      hold_value <= '0;
      hold_we    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        hold_addr  <= d_addr_in;
        hold_value <= d_value_in;
        hold_we    <= d_we_in;
        last_grant <= OWNER_D;
      end else if (grant_i) begin
        hold_addr  <= i_addr_in;
        hold_value <= '0;
        hold_we    <= 1'b0;
        last_grant <= OWNER_I;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
    end
  end

  // NOTE: the owner storage is not reset; an entry is only read while count says it holds valid data.
  always_ff @(posedge clk_in) begin
    if (push) owner_mem[wr_ptr] <= grant_i ? OWNER_I : OWNER_D;
  end

endmodule

// File: tb/tb_l1_lc_arbiter.sv
// Directed bench for l1_lc_arbiter: queued expectations for LC requests and L1 responses,
// checked by a monitor whenever a handshake is seen, plus direct checks of flow control.
`timescale 1ns/1ps
module tb_l1_lc_arbiter;
  localparam int PB = 22;
  localparam int LB = 512;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_valid, d_we, i_valid;
  logic [PB-1:0] d_addr, i_addr, lc_addr_in;
  logic [LB-1:0] d_value, lc_value_in;
  logic          d_rsp_ready, i_rsp_ready, lc_ready_in, lc_valid_in;
  logic          d_ready_out, i_ready_out, d_rsp_valid_out, i_rsp_valid_out;
  logic [PB-1:0] rsp_addr_out, lc_addr_out;
  logic [LB-1:0] rsp_value_out, lc_value_out;
  logic          lc_valid_out, lc_we_out, lc_ready_out, unexpected_rsp_out;
  logic [CW-1:0] outstanding_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [PB-1:0] addr;
    logic [LB-1:0] value;
    logic          we;
  } lc_req_t;

  typedef struct {
    logic          owner; // 0 = D, 1 = I
    logic [PB-1:0] addr;
    logic [LB-1:0] value;
  } rsp_t;

  lc_req_t lc_q[$];
  rsp_t    rsp_q[$];

  l1_lc_arbiter #(.PADDR_BITS(PB), .LINE_BITS(LB), .MAX_OUTSTANDING(MO)) dut (
    .clk_in(clk), .rst_in(rst),
    .d_valid_in(d_valid), .d_ready_out(d_ready_out), .d_addr_in(d_addr),
    .d_value_in(d_value), .d_we_in(d_we),
    .i_valid_in(i_valid), .i_ready_out(i_ready_out), .i_addr_in(i_addr),
    .d_rsp_valid_out(d_rsp_valid_out), .d_rsp_ready_in(d_rsp_ready),
    .i_rsp_valid_out(i_rsp_valid_out), .i_rsp_ready_in(i_rsp_ready),
    .rsp_addr_out(rsp_addr_out), .rsp_value_out(rsp_value_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in),
    .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
    .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out),
    .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in),
    .outstanding_out(outstanding_out), .unexpected_rsp_out(unexpected_rsp_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake did not happen within the cycle budget", name);
  endtask

  task automatic exp_lc(input logic [PB-1:0] a, input logic [LB-1:0] v, input logic we);
    lc_req_t e;
    e.addr = a; e.value = v; e.we = we;
    lc_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic owner, input logic [PB-1:0] a, input logic [LB-1:0] v);
    rsp_t e;
    e.owner = owner; e.addr = a; e.value = v;
    rsp_q.push_back(e);
  endtask

  // Monitor: compares every LC request and every L1 response handshake against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (lc_valid_out && lc_ready_in) begin
        if (lc_q.size() == 0) fail_now("lc_req_unexpected");
        else begin
          lc_req_t e;
          e = lc_q.pop_front();
          check("lc_addr", LB'(lc_addr_out), LB'(e.addr));
          check("lc_value", lc_value_out, e.value);
          check("lc_we", LB'(lc_we_out), LB'(e.we));
        end
      end
      if (d_rsp_valid_out && d_rsp_ready) begin
        if (rsp_q.size() == 0) fail_now("d_rsp_unexpected");
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("d_rsp_owner", 0, LB'(r.owner));
          check("d_rsp_addr", LB'(rsp_addr_out), LB'(r.addr));
          check("d_rsp_value", rsp_value_out, r.value);
          check("d_rsp_i_quiet", LB'(i_rsp_valid_out), 0);
        end
      end
      if (i_rsp_valid_out && i_rsp_ready) begin
        if (rsp_q.size() == 0) fail_now("i_rsp_unexpected");
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("i_rsp_owner", 1, LB'(r.owner));
          check("i_rsp_addr", LB'(rsp_addr_out), LB'(r.addr));
          check("i_rsp_value", rsp_value_out, r.value);
          check("i_rsp_d_quiet", LB'(d_rsp_valid_out), 0);
        end
      end
    end
  end

  // Present a request, wait (bounded) for its ready, record the expected LC request.
  task automatic issue_req(input logic is_i, input logic [PB-1:0] a, input logic [LB-1:0] v,
                           input logic we);
    bit done = 0;
    if (is_i) begin i_valid = 1; i_addr = a; end
    else begin d_valid = 1; d_addr = a; d_value = v; d_we = we; end
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (is_i ? i_ready_out : d_ready_out) begin
        exp_lc(a, is_i ? '0 : v, is_i ? 1'b0 : we);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (is_i) i_valid = 0; else d_valid = 0;
    if (!done) fail_now(is_i ? "i_grant_timeout" : "d_grant_timeout");
  endtask

  // Drive one LC response and hold it until the arbiter accepts it (bounded).
  task automatic lc_respond(input logic [PB-1:0] a, input logic [LB-1:0] v, input logic owner);
    bit done = 0;
    exp_rsp(owner, a, v);
    lc_valid_in = 1; lc_addr_in = a; lc_value_in = v;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (lc_ready_out) done = 1;
      @(posedge clk); #1;
    end
    lc_valid_in = 0;
    if (!done) fail_now("rsp_timeout");
  endtask

  task automatic do_reset();
    rst = 1;
    lc_q.delete();
    rsp_q.delete();
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; d_valid = 0; d_we = 0; i_valid = 0; d_addr = '0; i_addr = '0; d_value = '0;
    lc_valid_in = 0; lc_addr_in = '0; lc_value_in = '0;
    d_rsp_ready = 1; i_rsp_ready = 1; lc_ready_in = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_lc_ready", LB'(lc_ready_out), 1);
    check("rst_lc_valid", LB'(lc_valid_out), 0);
    check("rst_outstanding", LB'(outstanding_out), 0);
    check("rst_d_ready", LB'(d_ready_out), 0);
    check("rst_i_ready", LB'(i_ready_out), 0);
    check("rst_unexpected", LB'(unexpected_rsp_out), 0);
    check("rst_lc_addr", LB'(lc_addr_out), 0);
    check("rst_lc_we", LB'(lc_we_out), 0);
    rst = 0;
    @(posedge clk); #1;

    // Single D read.
    d_addr = 22'h02000; d_we = 0; d_value = '0; d_valid = 1;
    #1;
    check("s1_d_ready", LB'(d_ready_out), 1);
    check("s1_i_ready", LB'(i_ready_out), 0);
    exp_lc(22'h02000, '0, 1'b0);
    @(posedge clk); #1;
    d_valid = 0;
    #1;
    check("s1_lc_valid", LB'(lc_valid_out), 1);
    check("s1_outstanding", LB'(outstanding_out), 1);
    check("s1_no_ready_send", LB'(d_ready_out), 0);
    @(posedge clk); #1;
    exp_rsp(1'b0, 22'h02000, 512'hDEADBEEF);
    lc_valid_in = 1; lc_addr_in = 22'h02000; lc_value_in = 512'hDEADBEEF;
    #1;
    check("s1_d_rsp_valid", LB'(d_rsp_valid_out), 1);
    check("s1_i_rsp_valid", LB'(i_rsp_valid_out), 0);
    check("s1_rsp_value", rsp_value_out, 512'hDEADBEEF);
    @(posedge clk); #1;
    lc_valid_in = 0;
    #1;
    check("s1_outstanding_back", LB'(outstanding_out), 0);

    // Both requesters valid from reset: D wins first, then strict alternation.
    do_reset();
    d_addr = 22'h04040; d_we = 0; d_value = '0; d_valid = 1;
    i_addr = 22'h01000; i_valid = 1;
    exp_lc(22'h04040, '0, 1'b0);
    exp_lc(22'h01000, '0, 1'b0);
    exp_lc(22'h04040, '0, 1'b0);
    exp_lc(22'h01000, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("s2_d_ready", LB'(d_ready_out), LB'(k == 0 || k == 4));
      check("s2_i_ready", LB'(i_ready_out), LB'(k == 2 || k == 6));
      @(posedge clk); #1;
    end
    d_valid = 0; i_valid = 0;
    #1;
    check("s2_outstanding_full", LB'(outstanding_out), 4);
    lc_respond(22'h04040, 512'hA, 1'b0);
    lc_respond(22'h01000, 512'hB, 1'b1);
    lc_respond(22'h04040, 512'hC, 1'b0);
    lc_respond(22'h01000, 512'hD, 1'b1);
    #1;
    check("s2_outstanding_drained", LB'(outstanding_out), 0);

    // D writeback gets no response slot; a following I read still routes to I.
    issue_req(1'b0, 22'h05000, 512'h55AA, 1'b1);
    #1;
    check("s3_lc_we", LB'(lc_we_out), 1);
    check("s3_lc_value", lc_value_out, 512'h55AA);
    check("s3_outstanding", LB'(outstanding_out), 0);
    issue_req(1'b1, 22'h07000, '0, 1'b0);
    lc_respond(22'h07000, 512'h77, 1'b1);
    #1;
    check("s3_outstanding_after", LB'(outstanding_out), 0);

    // Fill the owner FIFO, confirm reads stall while writes pass.
    for (int k = 0; k < 4; k++) issue_req(1'b0, PB'(22'h00100 + k), '0, 1'b0);
    @(posedge clk); #1;
    check("s4_outstanding_4", LB'(outstanding_out), 4);
    d_addr = 22'h00104; d_we = 0; d_value = '0; d_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("s4_full_read_blocked", LB'(d_ready_out), 0);
      @(posedge clk); #1;
    end
    d_valid = 0;
    issue_req(1'b0, 22'h00200, 512'h1234, 1'b1);
    @(posedge clk); #1;
    check("s4_write_no_slot", LB'(outstanding_out), 4);
    d_addr = 22'h00104; d_we = 0; d_value = '0; d_valid = 1;
    exp_rsp(1'b0, 22'h00100, 512'h100);
    lc_valid_in = 1; lc_addr_in = 22'h00100; lc_value_in = 512'h100;
    #1;
    check("s4_pop_same_cycle_blocked", LB'(d_ready_out), 0);
    check("s4_pop_lc_ready", LB'(lc_ready_out), 1);
    @(posedge clk); #1;
    lc_valid_in = 0;
    #1;
    check("s4_read_after_pop", LB'(d_ready_out), 1);
    check("s4_outstanding_3", LB'(outstanding_out), 3);
    exp_lc(22'h00104, '0, 1'b0);
    @(posedge clk); #1;
    d_valid = 0;
    check("s4_outstanding_refill", LB'(outstanding_out), 4);
    for (int k = 1; k < 5; k++) lc_respond(PB'(22'h00100 + k), LB'(32'h100 + k), 1'b0);
    #1;
    check("s4_outstanding_drained", LB'(outstanding_out), 0);

    // LC request backpressure: payload held, no new grants.
    lc_ready_in = 0;
    issue_req(1'b0, 22'h06000, 512'hABCD, 1'b1);
    i_addr = 22'h08000; i_valid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("s5_lc_valid_held", LB'(lc_valid_out), 1);
      check("s5_lc_addr_held", LB'(lc_addr_out), LB'(22'h06000));
      check("s5_lc_value_held", lc_value_out, 512'hABCD);
      check("s5_no_i_ready", LB'(i_ready_out), 0);
      @(posedge clk); #1;
    end
    lc_ready_in = 1;
    @(posedge clk); #1;
    #1;
    check("s5_i_granted", LB'(i_ready_out), 1);
    exp_lc(22'h08000, '0, 1'b0);
    @(posedge clk); #1;
    i_valid = 0;

    // Response backpressure from I.
    i_rsp_ready = 0;
    exp_rsp(1'b1, 22'h08000, 512'h88);
    lc_valid_in = 1; lc_addr_in = 22'h08000; lc_value_in = 512'h88;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("s5_lc_ready_low", LB'(lc_ready_out), 0);
      check("s5_i_rsp_valid", LB'(i_rsp_valid_out), 1);
      check("s5_d_rsp_quiet", LB'(d_rsp_valid_out), 0);
      @(posedge clk); #1;
    end
    i_rsp_ready = 1;
    #1;
    check("s5_lc_ready_high", LB'(lc_ready_out), 1);
    @(posedge clk); #1;
    lc_valid_in = 0;
    #1;
    check("s5_outstanding", LB'(outstanding_out), 0);

    // Response with nothing outstanding.
    lc_valid_in = 1; lc_addr_in = 22'h00003; lc_value_in = 512'h33;
    #1;
    check("s6_unexpected", LB'(unexpected_rsp_out), 1);
    check("s6_lc_ready", LB'(lc_ready_out), 1);
    check("s6_d_rsp_quiet", LB'(d_rsp_valid_out), 0);
    check("s6_i_rsp_quiet", LB'(i_rsp_valid_out), 0);
    @(posedge clk); #1;
    lc_valid_in = 0;
    #1;
    check("s6_unexpected_gone", LB'(unexpected_rsp_out), 0);
    check("s6_outstanding", LB'(outstanding_out), 0);

    // Reset while a request is waiting in SEND.
    lc_ready_in = 0;
    issue_req(1'b0, 22'h09000, '0, 1'b0);
    #1;
    check("s7_lc_valid_send", LB'(lc_valid_out), 1);
    check("s7_outstanding_1", LB'(outstanding_out), 1);
    rst = 1;
    #1;
    check("s7_lc_valid_dropped", LB'(lc_valid_out), 0);
    check("s7_outstanding_cleared", LB'(outstanding_out), 0);
    check("s7_lc_ready", LB'(lc_ready_out), 1);
    lc_q.delete();
    rsp_q.delete();
    lc_ready_in = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("s7_idle_after_reset", LB'(lc_valid_out), 0);

    check("lc_q_drained", LB'(lc_q.size()), 0);
    check("rsp_q_drained", LB'(rsp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
